mem_block_mover: RTL

Bus-initiator block for the 8-bit nRISC data memory: copies a block of bytes from one data-memory region to another, or fills a region with a constant byte. It sits beside the processor on the data-memory port and drives address, write data and write strobe, sampling the memory's combinational read data. While it is busy, the processor is held off the port through `Busy`. Addresses are 8-bit and wrap modulo 256.

---
 rtl/mem_block_mover.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mem_block_mover.sv
// mem_block_mover
// Data-memory bus initiator that copies a byte block between two regions or
// fills a region with a constant byte. Addresses wrap modulo 256. The memory
// port is driven by a decode of the current state and the captured request.
module mem_block_mover (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Mode,
    input  logic [7:0] SrcAddr,
    input  logic [7:0] DstAddr,
    input  logic [7:0] Length,
    input  logic [7:0] FillValue,
    output logic       Busy,
    output logic       Done,
    output logic [7:0] MemAddress,
    output logic [7:0] MemWriteData,
    output logic       MemWrite,
    input  logic [7:0] MemData
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0] state_r;
    logic       mode_r;
    logic [7:0] src_r;
    logic [7:0] dst_r;
    logic [7:0] fill_r;
    logic [7:0] cnt_r;
    logic [7:0] idx_r;
    logic [7:0] buf_r;

    // Request capture, transfer sequencing and byte staging between READ and WRITE.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r <= ST_IDLE;
            mode_r  <= 1'b0;
            src_r   <= 8'h00;
            dst_r   <= 8'h00;
            fill_r  <= 8'h00;
            cnt_r   <= 8'h00;
            idx_r   <= 8'h00;
            buf_r   <= 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (Start) begin
                        mode_r <= Mode;
                        src_r  <= SrcAddr;
                        dst_r  <= DstAddr;
                        fill_r <= FillValue;
                        cnt_r  <= Length;
                        idx_r  <= 8'h00;
                        if (Length == 8'd0) begin
                            state_r <= ST_DONE;
                        end else if (Mode) begin
                            state_r <= ST_WRITE;
                        end else begin
                            state_r <= ST_READ;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    buf_r   <= MemData;
                    state_r <= ST_WRITE;
                end
                ST_WRITE: begin
                    idx_r <= idx_r + 8'd1;
                    cnt_r <= cnt_r - 8'd1;
                    // Last byte: cnt is checked before its decrement lands.
                    if (cnt_r == 8'd1) begin
                        state_r <= ST_DONE;
                    end else if (mode_r) begin
                        state_r <= ST_WRITE;
                    end else begin
                        state_r <= ST_READ;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Memory-port and status decode from the current state and captured request.
    always_comb begin
        Busy         = 1'b0;
        Done         = 1'b0;
        MemAddress   = 8'h00;
        MemWriteData = 8'h00;
        MemWrite     = 1'b0;
        case (state_r)
            ST_READ: begin
                Busy       = 1'b1;
                MemAddress = src_r + idx_r;
            end
            ST_WRITE: begin
                Busy       = 1'b1;
                MemAddress = dst_r + idx_r;
                MemWrite   = 1'b1;
                if (mode_r) begin
                    MemWriteData = fill_r;
                end else begin
                    MemWriteData = buf_r;
                end
            end
            ST_DONE: begin
                Done = 1'b1;
            end
            default: begin
                Busy = 1'b0;
            end
        endcase
    end

endmodule
